// File: rtl/odometer_pkg.sv
// -----------------------------------------------------------------------------
// odometer_pkg
// Shared definitions for the odometer measurement sequencer:
//   - BF_W             : width of the detector beat-frequency count
//   - DEF_*            : default timing / averaging constants
//   - meas_state_t     : sequencer FSM state encoding
// -----------------------------------------------------------------------------
package odometer_pkg;

    localparam int BF_W            = 12;
    localparam int DEF_N_AVG       = 4;
    localparam int DEF_SETTLE_CYC  = 8;
    localparam int DEF_TIMEOUT_CYC = 4096;
    localparam int DEF_ACC_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_TRIG    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RELEASE = 3'd4,
        ST_DONE    = 3'd5
    } meas_state_t;

endpackage

// File: rtl/odometer_sync2.sv
// -----------------------------------------------------------------------------
// odometer_sync2
// Two-flop synchronizer for single-bit signals arriving asynchronously to CLK.
// Ports:
//   CLK    in   destination clock
//   RESETB in   asynchronous active-low reset (output forced to 0)
//   D      in   asynchronous input
//   Q      out  synchronized output, 2 CLK cycles of latency
// -----------------------------------------------------------------------------
module odometer_sync2 (
    input  logic CLK,
    input  logic RESETB,
    input  logic D,
    output logic Q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true 2-stage chain.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            meta <= 1'b0;
            Q    <= 1'b0;
        end else begin
            meta <= D;
            Q    <= meta;
        end
    end

endmodule

// File: rtl/odometer_meas_seq.sv
// -----------------------------------------------------------------------------
// odometer_meas_seq
// Measurement sequencer for the odometer beat-frequency detector. Runs N_AVG
// stress/trigger/capture cycles, accumulates the captured counts and presents
// the sum in parallel (RESULT) and through a serial scan-out register (SOUT).
// Ports:
//   CLK, RESETB       clock, asynchronous active-low reset
//   START             1-cycle pulse, starts a run when idle
//   MEAS_DONE         detector done flag (asynchronous, synchronized here)
//   BF_COUNTER        detector count, stable while MEAS_DONE is high
//   DEADZONE_MSB      detector dead-zone flag (asynchronous, synchronized here)
//   SHIFT_EN          shift the scan register one bit per CLK while idle
//   MEAS_STRESS       detector stress enable
//   MEAS_TRIG         detector trigger; low clears the detector's done flag
//   BUSY              run in progress
//   RESULT_VALID      RESULT holds a finished run
//   RESULT            sum of captured counts
//   DZ_SEEN           a capture in the run had the dead-zone flag set
//   TIMEOUT_ERR       a measurement in the run timed out
//   SOUT              scan register MSB
// -----------------------------------------------------------------------------
module odometer_meas_seq
    import odometer_pkg::*;
#(
    parameter int N_AVG       = DEF_N_AVG,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int ACC_W       = DEF_ACC_W
) (
    input  logic             CLK,
    input  logic             RESETB,
    input  logic             START,
    input  logic             MEAS_DONE,
    input  logic [BF_W-1:0]  BF_COUNTER,
    input  logic             DEADZONE_MSB,
    input  logic             SHIFT_EN,
    output logic             MEAS_STRESS,
    output logic             MEAS_TRIG,
    output logic             BUSY,
    output logic             RESULT_VALID,
    output logic [ACC_W-1:0] RESULT,
    output logic             DZ_SEEN,
    output logic             TIMEOUT_ERR,
    output logic             SOUT
);

    localparam int TMR_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam int CNT_W   = $clog2(N_AVG + 1);

    meas_state_t       state;
    logic [TMR_W-1:0]  timer;
    logic [CNT_W-1:0]  meas_cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sr;
    logic [ACC_W:0]    acc_sum;
    logic              done_s;
    logic              dz_s;

    odometer_sync2 u_sync_done (.CLK(CLK), .RESETB(RESETB), .D(MEAS_DONE),    .Q(done_s));
    odometer_sync2 u_sync_dz   (.CLK(CLK), .RESETB(RESETB), .D(DEADZONE_MSB), .Q(dz_s));

    // One extra bit catches the carry used for saturation.
    assign acc_sum = {1'b0, acc} + {{(ACC_W + 1 - BF_W){1'b0}}, BF_COUNTER};
    assign SOUT    = sr[ACC_W-1];

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state        <= ST_IDLE;
            timer        <= '0;
            meas_cnt     <= '0;
            acc          <= '0;
            sr           <= '0;
            RESULT       <= '0;
            RESULT_VALID <= 1'b0;
            BUSY         <= 1'b0;
            DZ_SEEN      <= 1'b0;
            TIMEOUT_ERR  <= 1'b0;
            MEAS_STRESS  <= 1'b0;
            MEAS_TRIG    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // START has priority over SHIFT_EN.
                    if (START) begin
                        state        <= ST_ARM;
                        timer        <= '0;
                        meas_cnt     <= '0;
                        acc          <= '0;
                        DZ_SEEN      <= 1'b0;
                        TIMEOUT_ERR  <= 1'b0;
                        RESULT_VALID <= 1'b0;
                        BUSY         <= 1'b1;
                        MEAS_STRESS  <= 1'b1;
                    end else if (SHIFT_EN) begin
                        sr <= sr << 1;
                    end
                end
                ST_ARM: begin
                    // A done flag still high from the previous measurement holds
                    // the settle count at zero until the detector has cleared.
                    if (done_s) begin
                        timer <= '0;
                    end else if (timer == TMR_W'(SETTLE_CYC - 1)) begin
                        state     <= ST_TRIG;
                        MEAS_TRIG <= 1'b1;
                        timer     <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_TRIG: begin
                    if (done_s) begin
                        state <= ST_CAPTURE;
                    end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                        state       <= ST_RELEASE;
                        TIMEOUT_ERR <= 1'b1;
                        MEAS_TRIG   <= 1'b0;
                        MEAS_STRESS <= 1'b0;
                        timer       <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    // BF_COUNTER is sampled raw: done_s lags MEAS_DONE by two
                    // cycles, so the count has long been stable.
                    acc         <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
                    DZ_SEEN     <= DZ_SEEN | dz_s;
                    state       <= ST_RELEASE;
                    MEAS_TRIG   <= 1'b0;
                    MEAS_STRESS <= 1'b0;
                    timer       <= '0;
                end
                ST_RELEASE: begin
                    // First cycle only marks entry, guaranteeing at least two
                    // cycles with the trigger low.
                    if (timer == '0) begin
                        timer <= timer + 1'b1;
                    end else if (!done_s) begin
                        meas_cnt <= meas_cnt + 1'b1;
                        timer    <= '0;
                        if (meas_cnt == CNT_W'(N_AVG - 1)) begin
                            state <= ST_DONE;
                        end else begin
                            state       <= ST_ARM;
                            MEAS_STRESS <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    RESULT       <= acc;
                    sr           <= acc;
                    RESULT_VALID <= 1'b1;
                    BUSY         <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
